// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the ID-stage hazard/stall controller: FSM encoding,
// stall-need classification and the debug view of the sequencer.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NEED_0 = 2'd0,
    NEED_1 = 2'd1,
    NEED_2 = 2'd2
  } stall_need_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    state_e state;
    logic   rem;
  } dbg_t;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module hazard_stall_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detection: classifies load-use / branch hazards against EX
// and MEM producers and sequences the resulting one- or two-cycle stalls.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] registerRsID,
  input  logic [REG_W-1:0] registerRtID,
  input  logic             useRtID,
  input  logic             branchID,
  input  logic             branchTakenID,
  input  logic             jumpID,
  input  logic             memReadEX,
  input  logic             regWriteEX,
  input  logic [REG_W-1:0] writeRegEX,
  input  logic             memReadMEM,
  input  logic [REG_W-1:0] registerRdMEM,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             idExFlush,
  output logic             ifIdFlush,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output dbg_t             dbg_o
);

  // Handshake-free block: every output is a per-cycle level; a stall cycle
  // freezes PC and IF/ID and bubbles ID/EX, and it always masks a flush.

  logic        match_ex;
  logic        match_mem;
  stall_need_e need;
  state_e      state_q, state_d;
  logic        rem_q, rem_d;
  logic        stall;
  logic        flush_req;

  assign match_ex  = (writeRegEX != REG_W'(REG_ZERO)) &&
                     ((writeRegEX == registerRsID) ||
                      (useRtID && (writeRegEX == registerRtID)));
  assign match_mem = (registerRdMEM != REG_W'(REG_ZERO)) &&
                     ((registerRdMEM == registerRsID) ||
                      (useRtID && (registerRdMEM == registerRtID)));

  always_comb begin
    need = NEED_0;
    if (branchID && memReadEX && match_ex) begin
      need = NEED_2;
    end else if (memReadEX && match_ex) begin
      need = NEED_1;
    end else if (branchID && regWriteEX && !memReadEX && match_ex) begin
      need = NEED_1;
    end else if (branchID && memReadMEM && match_mem) begin
      need = NEED_1;
    end
  end

  // HOLD covers the second stall of a branch-after-load without looking at
  // the hazard inputs again.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (need != NEED_0) begin
          stall = 1'b1;
        end
        if (need == NEED_2) begin
          state_d = ST_HOLD;
          rem_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        stall   = 1'b1;
        state_d = ST_IDLE;
        rem_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign flush_req = !stall && (jumpID || (branchID && branchTakenID));

  always_comb begin
    pcWrite   = 1'b1;
    ifIdWrite = 1'b1;
    idExFlush = 1'b0;
    ifIdFlush = flush_req;
    if (!rst_n) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
      ifIdFlush = 1'b1;
    end else if (stall) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
      ifIdFlush = 1'b0;
    end
  end

  hazard_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stall),
    .cnt_o (stallCount)
  );

  hazard_stall_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (flush_req),
    .cnt_o (flushCount)
  );

  assign dbg_o = '{state: state_q, rem: rem_q};

endmodule
